rib_uart_tx: RTL and testbench
==============================

Name: rib_uart_tx

Overview:
- Buffered UART transmitter; RIB slave responder; transmit-side counterpart of the uart_debug downloader.
- Core writes bytes over RIB into a TX FIFO. A frame engine serialises them onto tx_pin.
- When the FIFO is full, a write to TXDATA is stalled through the RIB ready handshake.
- An optional completion interrupt feeds int_flag.

Parameters:
- FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..256.
- DEFAULT_BAUD_DIV, 434, reset value of BAUD register in clk cycles per bit (50 MHz / 115200).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- req_i  in  1  RIB request, qualifies addr_i/we_i/data_i
- we_i  in  1  1 = write, 0 = read
- addr_i  in  32  byte address; only addr_i[3:2] decoded
- data_i  in  32  write data
- data_o  out  32  read data
- ready_o  out  1  RIB ready; transfer completes in a cycle with req_i=1 and ready_o=1
- tx_pin  out  1  UART serial output, idle high
- int_o  out  1  level interrupt to int_flag

Behaviour:
- Register map (addr_i[3:2]):
  - 0 CTRL, rw:
    - bit0 tx_en
    - bit1 int_en
    - bit2 parity_en (see optional feature)
    - bit3 flush: write-1 pulse, reads 0
  - 1 STATUS, ro:
    - bit0 busy
    - bit1 full
    - bit2 empty
    - [15:8] fifo count
  - 2 BAUD, rw, [15:0]:
    - written values below 4 are stored as 4
    - [31:16] read 0
  - 3 TXDATA, wo:
    - write pushes data_i[7:0]
    - read returns 0
- Reset values:
  - outputs: tx_pin=1, int_o=0, data_o=0
  - CTRL=0, BAUD=DEFAULT_BAUD_DIV, FIFO empty, FSM IDLE
- ready_o is combinational:
  - 0 only when req_i & we_i & addr_i[3:2]==3 & full
  - 1 otherwise, including when idle
- Reads: data_o combinational, valid in the same cycle as req_i; data_o=0 when req_i=0 or we_i=1.
- Writes: take effect on the clk edge where req_i & ready_o.
- FIFO full:
  - stalled push is held until a pop frees a slot; accepted the cycle after the pop (no same-cycle bypass).
  - count never exceeds FIFO_DEPTH; no data loss.
- FIFO empty: no pop; FSM stays IDLE.
- Pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop when not full: count unchanged.
- Flush:
  - empties the FIFO in one cycle.
  - a frame in progress completes.
  - a push in the same cycle as flush is discarded.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when tx_en & !empty; pops byte into shift register; latches BAUD into bit-period counter reload.
  - START: tx_pin=0 for BAUD cycles.
  - DATA: 8 bits, LSB first, BAUD cycles each, 3-bit bit counter.
  - DATA -> PARITY if parity active, else STOP.
  - STOP: tx_pin=1 for BAUD cycles.
  - STOP -> START back-to-back if tx_en & !empty; else IDLE.
- BAUD write mid-frame: applies from the next frame only.
- tx_en cleared mid-frame: current frame completes, then IDLE.
- busy = (state != IDLE).
- int_o is registered: int_o <= int_en & empty & !busy; updates one cycle after the condition changes.
- Reset asserted mid-frame: immediate return to reset values; tx_pin=1 asynchronously.

Optional Feature:
- Macro: RIB_UART_TX_PARITY_EN
- Defined:
  - CTRL bit2 parity_en is writable.
  - When set, the PARITY state sends the even-parity bit (XOR of the 8 data bits) for BAUD cycles.
  - Frame = 11 bits.
- Undefined:
  - CTRL bit2 reads 0, writes ignored.
  - PARITY state is never entered.
  - Frame = 10 bits; no parity logic synthesised.

Test Plan:
1. Reset, read all registers:
   - CTRL=0, STATUS=0x00000004, BAUD=434, tx_pin=1, int_o=0, ready_o=1.
2. BAUD=4, CTRL=1, write TXDATA=0xA5:
   - tx_pin sequence 0,1,0,1,0,0,1,0,1,1, each level held exactly 4 clk.
   - busy drops after 40 cycles.
3. BAUD=4, CTRL=0, write 17 bytes 0x00..0x10 (FIFO_DEPTH=16):
   - 17th write sees ready_o=0; STATUS=0x00001002.
   - set CTRL=1: stall releases the cycle after the first pop; all 17 bytes appear in order.
4. Write BAUD=1:
   - read back 4.
   - BAUD=8 written mid-frame: current frame keeps 4-cycle bits, next frame uses 8.
5. CTRL=3, one byte sent:
   - int_o rises one cycle after busy falls with FIFO empty.
   - flush (CTRL=0xB) with 5 queued bytes: count=0, in-flight frame completes intact.
6. With RIB_UART_TX_PARITY_EN, CTRL=5, send 0x07:
   - parity bit 1, frame 11 bits.
   - without the macro, CTRL reads back 1 and frame is 10 bits.

Source files
------------

// File: rtl/rib_uart_tx.sv
// Buffered UART transmitter behind a RIB slave port: TX FIFO plus 8N1 frame engine.
// Define RIB_UART_TX_PARITY_EN to add an optional even-parity bit (CTRL bit2).
//
// state  | meaning
// IDLE   | line high, waiting for tx_en and a queued byte
// START  | start bit (low) for one bit period
// DATA   | 8 data bits, LSB first
// PARITY | even-parity bit (only with RIB_UART_TX_PARITY_EN)
// STOP   | stop bit (high); may chain straight into the next START
module rib_uart_tx #(
    parameter int FIFO_DEPTH       = 16,
    parameter int DEFAULT_BAUD_DIV = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ready_o,
    output logic        tx_pin,
    output logic        int_o
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [15:0]   BAUD_RST = 16'(DEFAULT_BAUD_DIV);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t          state, state_nxt;
    logic            tx_en, int_en, parity_en;
    logic [15:0]     baud, baud_lat, bit_cnt;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [7:0]      shreg;
    logic [2:0]      bit_idx;
    logic            full, empty, busy, bit_tc, pop, can_start;
    logic            wr_acc, flush, push;
    logic [1:0]      sel;
    logic [8:0]      cnt_w;
    logic [7:0]      status_cnt;
    logic            unused_bits;

    assign sel       = addr_i[3:2];
    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign busy      = (state != S_IDLE);
    assign bit_tc    = (bit_cnt == 16'd0);
    assign ready_o   = !(req_i && we_i && (sel == 2'd3) && full);
    assign wr_acc    = req_i && we_i && ready_o;
    assign flush     = wr_acc && (sel == 2'd0) && data_i[3];
    assign push      = wr_acc && (sel == 2'd3) && !flush;
    assign can_start = tx_en && !empty && !flush;
    assign cnt_w      = 9'(count);
    assign status_cnt = cnt_w[8] ? 8'hFF : cnt_w[7:0];
    assign unused_bits = ^{addr_i[31:4], addr_i[1:0], data_i[31:16]};

`ifdef RIB_UART_TX_PARITY_EN
    logic par_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_en <= 1'b0;
            par_bit   <= 1'b0;
        end else begin
            if (wr_acc && (sel == 2'd0))
                parity_en <= data_i[2];
            if (pop)
                par_bit <= ^mem[rd_ptr];
        end
    end
`else
    assign parity_en = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_en  <= 1'b0;
            int_en <= 1'b0;
            baud   <= BAUD_RST;
            int_o  <= 1'b0;
        end else begin
            if (wr_acc && (sel == 2'd0)) begin
                tx_en  <= data_i[0];
                int_en <= data_i[1];
            end
            if (wr_acc && (sel == 2'd2))
                baud <= (data_i[15:0] < 16'd4) ? 16'd4 : data_i[15:0];
            int_o <= int_en && empty && !busy;
        end
    end

    // The stalled push only sees the freed slot after count updates, so no bypass path exists.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_i[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            shreg    <= 8'd0;
            baud_lat <= BAUD_RST;
            bit_cnt  <= 16'd0;
            bit_idx  <= 3'd0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                shreg    <= mem[rd_ptr];
                baud_lat <= baud;
                bit_cnt  <= baud - 16'd1;
                bit_idx  <= 3'd0;
            end else if (busy) begin
                if (bit_tc) begin
                    bit_cnt <= baud_lat - 16'd1;
                    if (state == S_DATA) begin
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end
                end else begin
                    bit_cnt <= bit_cnt - 16'd1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        tx_pin    = 1'b1;
        case (state)
            S_IDLE: begin
                if (can_start) begin
                    pop       = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                tx_pin = 1'b0;
                if (bit_tc)
                    state_nxt = S_DATA;
            end
            S_DATA: begin
                tx_pin = shreg[0];
                if (bit_tc && (bit_idx == 3'd7))
                    state_nxt = parity_en ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
`ifdef RIB_UART_TX_PARITY_EN
                tx_pin = par_bit;
`endif
                if (bit_tc)
                    state_nxt = S_STOP;
            end
            S_STOP: begin
                if (bit_tc) begin
                    if (can_start) begin
                        pop       = 1'b1;
                        state_nxt = S_START;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        data_o = 32'd0;
        if (req_i && !we_i) begin
            case (sel)
                2'd0:    data_o = {28'd0, 1'b0, parity_en, int_en, tx_en};
                2'd1:    data_o = {16'd0, status_cnt, 5'd0, empty, full, busy};
                2'd2:    data_o = {16'd0, baud};
                default: data_o = 32'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_rib_uart_tx.sv
// Self-checking bench for rib_uart_tx: directed RIB traffic, frame scoreboard on tx_pin.
module tb_rib_uart_tx;
`ifdef RIB_UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_i = 1'b0, we_i = 1'b0;
    logic [31:0] addr_i = '0, data_i = '0;
    logic [31:0] data_o;
    logic        ready_o, tx_pin, int_o;

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  mon_abort = 1'b0;
    logic int_at_rd;

    typedef struct {
        logic [7:0] data;
        int         baud;
        bit         par;
    } exp_t;
    exp_t exp_q[$];

    rib_uart_tx #(.FIFO_DEPTH(16), .DEFAULT_BAUD_DIV(434)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .data_i(data_i), .data_o(data_o), .ready_o(ready_o), .tx_pin(tx_pin), .int_o(int_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, output int stalls);
        int   guard;
        logic done;
        stalls = 0;
        guard  = 0;
        done   = 1'b0;
        req_i = 1'b1; we_i = 1'b1; addr_i = {28'd0, a, 2'b00}; data_i = d;
        while (!done) begin
            #1;
            done = ready_o;
            if (!done) stalls++;
            @(posedge clk);
            #1;
            guard++;
            if (!done && guard > 2000) begin
                chk("wr_timeout", 32'(guard), 32'd0);
                done = 1'b1;
            end
        end
        req_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic wrs(input logic [1:0] a, input logic [31:0] d);
        int s;
        wr(a, d, s);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        req_i = 1'b1; we_i = 1'b0; addr_i = {28'd0, a, 2'b00};
        #1;
        d = data_o;
        int_at_rd = int_o;
        @(posedge clk);
        #1;
        req_i = 1'b0;
    endtask

    task automatic tx_byte(input logic [7:0] b, input int bd, input bit par);
        exp_t e;
        e.data = b; e.baud = bd; e.par = par;
        exp_q.push_back(e);
        wrs(2'd3, {24'd0, b});
    endtask

    task automatic drain();
        int          g;
        logic [31:0] s;
        g = 0;
        do begin
            rd(2'd1, s);
            g++;
        end while ((exp_q.size() != 0 || s[0]) && g < 5000);
        chk("drain_timeout", 32'(g < 5000), 32'd1);
    endtask

    // Frame monitor: decodes every frame on tx_pin against the expected queue.
    initial begin
        exp_t        e;
        logic [10:0] ev, obs;
        int          nb, bad;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && !mon_abort && tx_pin === 1'b0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 32'd1, 32'd0);
                    for (int k = 0; k < 100 && tx_pin === 1'b0; k++) @(negedge clk);
                end else begin
                    e = exp_q.pop_front();
                    ev = '1;
                    ev[0] = 1'b0;
                    ev[8:1] = e.data;
                    if (e.par) ev[9] = ^e.data;
                    nb = e.par ? 11 : 10;
                    obs = '1;
                    bad = 0;
                    aborted = 1'b0;
                    for (int b = 0; b < nb; b++) begin
                        for (int c = 0; c < e.baud; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (mon_abort) aborted = 1'b1;
                            if (!aborted) begin
                                if (c == 0) obs[b] = tx_pin;
                                else if (tx_pin !== obs[b]) bad++;
                            end
                        end
                    end
                    if (!aborted) begin
                        chk($sformatf("frame_%02h", e.data), 32'(obs), 32'(ev));
                        chk("bit_width", 32'(bad), 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] s;
        int          stalls, busy_cyc;
        bit          seen;
        logic        int_fall, int_next;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_pin", 32'(tx_pin), 32'd1);
        chk("rst_int_o", 32'(int_o), 32'd0);
        rst = 1'b1;
        idle(2);

        // 1: reset register values
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_data_o_idle", data_o, 32'd0);
        rd(2'd0, s); chk("rst_ctrl", s, 32'd0);
        rd(2'd1, s); chk("rst_status", s, 32'h4);
        rd(2'd2, s); chk("rst_baud", s, 32'd434);
        rd(2'd3, s); chk("txdata_read", s, 32'd0);

        // 2: single 0xA5 frame at BAUD=4, busy for 40 cycles
        wrs(2'd2, 32'd4);
        wrs(2'd0, 32'd1);
        tx_byte(8'hA5, 4, 1'b0);
        busy_cyc = 0;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            rd(2'd1, s);
            if (s[0]) begin
                seen = 1'b1;
                busy_cyc++;
            end else if (seen) begin
                break;
            end
        end
        chk("busy_cycles", 32'(busy_cyc), 32'd40);
        drain();

        // 3: fill FIFO, stall the 17th write, release on first pop
        wrs(2'd0, 32'd0);
        for (int i = 0; i < 16; i++) begin
            exp_t e;
            e.data = 8'(i); e.baud = 4; e.par = 1'b0;
            exp_q.push_back(e);
            wrs(2'd3, 32'(i));
        end
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'hC; data_i = 32'h10;
        #1;
        chk("full_ready", 32'(ready_o), 32'd0);
        req_i = 1'b0; we_i = 1'b0;
        @(posedge clk);
        #1;
        rd(2'd1, s); chk("full_status", s, 32'h1002);
        wrs(2'd0, 32'd1);
        begin
            exp_t e;
            e.data = 8'h10; e.baud = 4; e.par = 1'b0;
            exp_q.push_back(e);
        end
        wr(2'd3, 32'h10, stalls);
        chk("stall_cycles", 32'(stalls), 32'd1);
        drain();

        // 4: BAUD clamp, BAUD change mid-frame
        wrs(2'd2, 32'd1);
        rd(2'd2, s); chk("baud_clamp", s, 32'd4);
        tx_byte(8'h3C, 4, 1'b0);
        tx_byte(8'hC3, 8, 1'b0);
        idle(3);
        wrs(2'd2, 32'd8);
        drain();

        // 5: completion interrupt timing, then flush with frame in flight
        wrs(2'd2, 32'd4);
        wrs(2'd0, 32'd3);
        idle(2);
        chk("int_idle_high", 32'(int_o), 32'd1);
        tx_byte(8'h5A, 4, 1'b0);
        seen = 1'b0;
        int_fall = 1'bx;
        int_next = 1'bx;
        for (int k = 0; k < 300; k++) begin
            rd(2'd1, s);
            if (s[0]) begin
                seen = 1'b1;
            end else if (seen) begin
                int_fall = int_at_rd;
                rd(2'd1, s);
                int_next = int_at_rd;
                break;
            end
        end
        chk("int_at_busy_fall", 32'(int_fall), 32'd0);
        chk("int_one_after", 32'(int_next), 32'd1);
        tx_byte(8'h11, 4, 1'b0);
        for (int i = 2; i <= 6; i++) wrs(2'd3, 32'h10 + 32'(i));
        wrs(2'd0, 32'hB);
        rd(2'd1, s); chk("flush_status", s, 32'h5);
        drain();
        rd(2'd1, s); chk("post_flush_status", s, 32'h4);
        chk("post_flush_int", 32'(int_o), 32'd1);
        rd(2'd0, s); chk("ctrl_flush_reads0", s, 32'd3);

        // 6: parity bit (11-bit frame) or parity disabled (10-bit frame)
        wrs(2'd0, 32'd5);
        rd(2'd0, s); chk("ctrl_parity", s, PAR ? 32'd5 : 32'd1);
        tx_byte(8'h07, 4, PAR);
        drain();

        // asynchronous reset mid-frame
        tx_byte(8'h99, 4, PAR);
        idle(10);
        chk("pre_reset_low", 32'(tx_pin), 32'd0);
        mon_abort = 1'b1;
        rst = 1'b0;
        #1;
        chk("async_rst_tx_pin", 32'(tx_pin), 32'd1);
        chk("async_rst_int", 32'(int_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);
        rd(2'd1, s); chk("rerst_status", s, 32'h4);
        rd(2'd2, s); chk("rerst_baud", s, 32'd434);
        rd(2'd0, s); chk("rerst_ctrl", s, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
